// File: rtl/prbs_pkg.sv
// Shared defaults and types for the PRBS checker: polynomial x^23 + x^18 + 1,
// generator seed, and the HUNT/LOCKED state encoding.
package prbs_pkg;

   localparam int POLY_LENGTH_DEF  = 23;
   localparam int POLY_TAP_DEF     = 18;
   localparam int WIDTH_DEF        = 17;
   localparam int LOCK_COUNT_DEF   = 8;
   localparam int UNLOCK_COUNT_DEF = 4;

   localparam logic [22:0] GEN_SEED = 23'h7FF800;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/prbs_step.sv
// One-word step of the LFSR sequence: expected word from the history plus the
// history that follows it, fed by expected bits (locked) or received bits (hunt).
module prbs_step #(
   parameter int POLY_LENGTH = 23,
   parameter int POLY_TAP    = 18,
   parameter int WIDTH       = 17
) (
   input  logic [POLY_LENGTH-1:0] hist_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   mode_i,
   output logic [WIDTH-1:0]       exp_o,
   output logic [POLY_LENGTH-1:0] next_hist_o
);

   // seq[0] is the oldest history bit; seq[POLY_LENGTH+k] is the bit at time k.
   logic [POLY_LENGTH+WIDTH-1:0] seq;

   always_comb begin
      seq                  = '0;
      seq[POLY_LENGTH-1:0] = hist_i;
      exp_o                = '0;
      for (int k = 0; k < WIDTH; k++) begin
         exp_o[WIDTH-1-k]   = seq[POLY_LENGTH+k-POLY_TAP] ^ seq[k];
         seq[POLY_LENGTH+k] = mode_i ? exp_o[WIDTH-1-k] : data_i[WIDTH-1-k];
      end
      next_hist_o = seq[WIDTH +: POLY_LENGTH];
   end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronising hunt, lock after a run of clean words, lose
// lock after a run of errored words; per-word error map and saturating counters.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int POLY_LENGTH  = POLY_LENGTH_DEF,
   parameter int POLY_TAP     = POLY_TAP_DEF,
   parameter int WIDTH        = WIDTH_DEF,
   parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
   parameter int UNLOCK_COUNT = UNLOCK_COUNT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             init,
   input  logic [WIDTH-1:0] data,
   output logic             locked,
   output logic             err_valid,
   output logic [WIDTH-1:0] err_bits,
   output logic [31:0]      err_count,
   output logic [31:0]      word_count,
   output state_e           state_dbg
);

   localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [POLY_LENGTH-1:0]   hist_q;
   logic                     err_valid_q;
   logic [WIDTH-1:0]         err_bits_q;
   logic [31:0]              err_count_q;
   logic [31:0]              word_count_q;

   logic [WIDTH-1:0]         exp_w;
   logic [WIDTH-1:0]         err_w;
   logic                     word_err;
   logic [POLY_LENGTH-1:0]   hist_d;
   logic [POLY_LENGTH-1:0]   hist_rx;
   logic [WIDTH-1:0]         data_rev;
   logic [POLY_LENGTH+WIDTH-1:0] rx_seq;
   logic [31:0]              pop;
   logic [32:0]              err_sum;
   logic [31:0]              err_count_d;
   logic [31:0]              word_count_d;

   prbs_step #(
      .POLY_LENGTH (POLY_LENGTH),
      .POLY_TAP    (POLY_TAP),
      .WIDTH       (WIDTH)
   ) u_step (
      .hist_i      (hist_q),
      .data_i      (data),
      .mode_i      (state_q == LOCKED),
      .exp_o       (exp_w),
      .next_hist_o (hist_d)
   );

   assign err_w    = exp_w ^ data;
   assign word_err = |err_w;

   // History rebuilt from received bits only, used when lock is lost.
   always_comb begin
      data_rev = '0;
      for (int k = 0; k < WIDTH; k++) begin
         data_rev[k] = data[WIDTH-1-k];
      end
   end
   assign rx_seq  = {data_rev, hist_q};
   assign hist_rx = rx_seq[WIDTH +: POLY_LENGTH];

   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + 32'(err_w[i]);
      end
   end

   assign err_sum      = {1'b0, err_count_q} + {1'b0, pop};
   assign err_count_d  = err_sum[32] ? '1 : err_sum[31:0];
   assign word_count_d = (word_count_q == '1) ? word_count_q : word_count_q + 32'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= HUNT;
         cnt_q        <= '0;
         hist_q       <= '0;
         err_valid_q  <= 1'b0;
         err_bits_q   <= '0;
         err_count_q  <= '0;
         word_count_q <= '0;
      end else if (init) begin
         state_q      <= HUNT;
         cnt_q        <= '0;
         err_valid_q  <= 1'b0;
         err_bits_q   <= '0;
         err_count_q  <= '0;
         word_count_q <= '0;
      end else if (en) begin
         err_valid_q <= 1'b1;
         err_bits_q  <= err_w;
         if (state_q == HUNT) begin
            hist_q <= hist_d;
            if (word_err) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
               state_q <= LOCKED;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            if (!word_err) begin
               cnt_q  <= '0;
               hist_q <= hist_d;
            end else if (cnt_q == CNT_W'(UNLOCK_COUNT - 1)) begin
               state_q <= HUNT;
               cnt_q   <= '0;
               hist_q  <= hist_rx;
            end else begin
               cnt_q  <= cnt_q + 1'b1;
               hist_q <= hist_d;
            end
         end
      end else begin
         err_valid_q <= 1'b0;
         err_bits_q  <= '0;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign err_valid  = err_valid_q;
   assign err_bits   = err_bits_q;
   assign err_count  = err_count_q;
   assign word_count = word_count_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: bit-queue reference model of the sequence rules,
// per-cycle compare against it, and hand-derived pins on key events.
module tb_prbs_checker;
   import prbs_pkg::*;

   localparam int PL = 23, PT = 18, W = 17, LOCKN = 8, UNLOCKN = 4;

   logic          clk = 1'b0, reset = 1'b1, en = 1'b0, init = 1'b0;
   logic [W-1:0]  data = '0;
   logic          locked, err_valid;
   logic [W-1:0]  err_bits;
   logic [31:0]   err_count, word_count;
   state_e        state_dbg;

   int total = 0, bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   prbs_checker dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .init       (init),
      .data       (data),
      .locked     (locked),
      .err_valid  (err_valid),
      .err_bits   (err_bits),
      .err_count  (err_count),
      .word_count (word_count),
      .state_dbg  (state_dbg)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- generator: sliding window of the last PL sequence bits
   bit gq[$];
   task automatic gen_word(output logic [W-1:0] w);
      bit b;
      w = '0;
      for (int k = 0; k < W; k++) begin
         b = gq[PL-PT] ^ gq[0];
         gq.push_back(b);
         void'(gq.pop_front());
         w[W-1-k] = b;
      end
   endtask

   // ---------------- reference model
   bit          mh[$];
   bit          seq[$];
   bit          rxs[$];
   logic        m_locked;
   int          m_cnt;
   logic        m_ev;
   logic [W-1:0] m_eb, ebits;
   longint      m_ec, m_wc;
   int          nerr;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mh.delete();
         for (int i = 0; i < PL; i++) mh.push_back(1'b0);
         m_locked = 1'b0; m_cnt = 0; m_ev = 1'b0; m_eb = '0; m_ec = 0; m_wc = 0;
      end else if (init) begin
         m_locked = 1'b0; m_cnt = 0; m_ev = 1'b0; m_eb = '0; m_ec = 0; m_wc = 0;
      end else if (en) begin
         seq = mh;
         rxs = mh;
         ebits = '0;
         for (int k = 0; k < W; k++) begin
            ebits[W-1-k] = seq[PL+k-PT] ^ seq[k];
            seq.push_back(m_locked ? ebits[W-1-k] : data[W-1-k]);
            rxs.push_back(data[W-1-k]);
         end
         while (seq.size() > PL) void'(seq.pop_front());
         while (rxs.size() > PL) void'(rxs.pop_front());
         m_eb = ebits ^ data;
         m_ev = 1'b1;
         nerr = $countones(m_eb);
         if (!m_locked) begin
            mh = seq;
            if (nerr != 0) m_cnt = 0;
            else begin
               m_cnt++;
               if (m_cnt == LOCKN) begin m_locked = 1'b1; m_cnt = 0; end
            end
         end else begin
            m_ec = m_ec + nerr;
            if (m_ec > 64'hFFFF_FFFF) m_ec = 64'hFFFF_FFFF;
            if (m_wc < 64'hFFFF_FFFF) m_wc = m_wc + 1;
            if (nerr == 0) begin
               m_cnt = 0; mh = seq;
            end else begin
               m_cnt++;
               if (m_cnt == UNLOCKN) begin m_locked = 1'b0; m_cnt = 0; mh = rxs; end
               else mh = seq;
            end
         end
      end else begin
         m_ev = 1'b0; m_eb = '0;
      end
   end

   // ---------------- per-cycle compare
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cyc_locked",     32'(locked),    32'(m_locked));
         chk("cyc_err_valid",  32'(err_valid), 32'(m_ev));
         chk("cyc_err_bits",   32'(err_bits),  32'(m_eb));
         chk("cyc_err_count",  err_count,      m_ec[31:0]);
         chk("cyc_word_count", word_count,     m_wc[31:0]);
      end
   end

   // ---------------- drivers
   task automatic send(input logic e, input logic i, input logic [W-1:0] d);
      en = e; init = i; data = d;
      @(posedge clk);
      #2;
   endtask

   task automatic send_gen();
      logic [W-1:0] w;
      gen_word(w);
      send(1'b1, 1'b0, w);
   endtask

   // ---------------- stimulus
   initial begin
      logic [W-1:0] w;
      logic [22:0]  sd;
      logic [31:0]  ec0, wc0;
      int           n, r;
      logic         e, i;

      sd = GEN_SEED;
      for (int k = 0; k < PL; k++) gq.push_back(sd[k]);

      #1 reset = 1'b0;
      #1 chk_on = 1'b1;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_valid", 32'(err_valid), 32'd0);
      chk("rst_err_bits", 32'(err_bits), 32'd0);
      chk("rst_counts", err_count | word_count, 32'd0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;

      // Seeded stream; words 1-2 miscompare against the zero history.
      gen_word(w);
      chk("gen_first_word", 32'(w), 32'h0_07C0);
      send(1'b1, 1'b0, w);
      chk("first_word_err", 32'(err_valid & (|err_bits)), 32'd1);
      repeat (8) send_gen();
      chk("not_locked_9", 32'(locked), 32'd0);
      send_gen();
      chk("locked_10", 32'(locked), 32'd1);
      chk("lock_word_uncounted", word_count, 32'd0);
      repeat (20) send_gen();
      chk("wc_20", word_count, 32'd20);
      chk("ec_0", err_count, 32'd0);

      // Single bit flip while locked.
      gen_word(w);
      w[5] = ~w[5];
      send(1'b1, 1'b0, w);
      chk("flip_bits", 32'(err_bits), 32'h0_0020);
      chk("flip_ec", err_count, 32'd1);
      chk("flip_locked", 32'(locked), 32'd1);
      send_gen();
      chk("flip_no_spread", 32'(err_bits), 32'd0);

      // Four inverted words: lose lock on the fourth.
      ec0 = err_count;
      for (int k = 0; k < 4; k++) begin
         gen_word(w);
         send(1'b1, 1'b0, ~w);
         if (k == 2) chk("inv3_still_locked", 32'(locked), 32'd1);
      end
      chk("inv_unlocked", 32'(locked), 32'd0);
      chk("inv_ec_68", err_count, ec0 + 32'd68);
      repeat (9) send_gen();
      chk("relock_not_9", 32'(locked), 32'd0);
      send_gen();
      chk("relock_10", 32'(locked), 32'd1);

      // Random en gaps in a clean locked stream.
      wc0 = word_count; ec0 = err_count; n = 0;
      repeat (60) begin
         if ($urandom_range(0, 2) == 0) send(1'b0, 1'b0, W'($urandom));
         else begin send_gen(); n++; end
      end
      chk("gap_wc", word_count, wc0 + 32'(n));
      chk("gap_ec", err_count, ec0);
      chk("gap_locked", 32'(locked), 32'd1);

      // Randomised mix: gaps, init, bit flips, inversions, garbage.
      repeat (400) begin
         e = ($urandom_range(0, 3) != 0);
         i = ($urandom_range(0, 50) == 0);
         if (e) begin
            gen_word(w);
            r = $urandom_range(0, 9);
            if (r == 0) w[$urandom_range(0, W-1)] ^= 1'b1;
            else if (r == 1) w = W'($urandom);
            else if (r == 2) w = ~w;
         end else w = W'($urandom);
         send(e, i, w);
      end

      // Reset mid-stream needs a full run of good words again.
      reset = 1'b0;
      #1 chk("rst_mid_locked", 32'(locked), 32'd0);
      #1 reset = 1'b1;
      repeat (7) send_gen();
      chk("rst_need_full_run", 32'(locked), 32'd0);
      repeat (3) send_gen();
      chk("rst_relock", 32'(locked), 32'd1);

      // Asynchronous drop while locked.
      repeat (3) send_gen();
      reset = 1'b0;
      #1 chk("async_drop", 32'(locked), 32'd0);
      chk("async_wc", word_count, 32'd0);
      #1 reset = 1'b1;
      repeat (10) send_gen();
      chk("async_relock", 32'(locked), 32'd1);

      // init beats en; history kept, so the next eight clean words relock.
      repeat (3) send_gen();
      send(1'b1, 1'b1, W'($urandom));
      chk("init_locked", 32'(locked), 32'd0);
      chk("init_counts", err_count | word_count, 32'd0);
      chk("init_err_valid", 32'(err_valid), 32'd0);
      repeat (7) send_gen();
      chk("init_not_7", 32'(locked), 32'd0);
      send_gen();
      chk("init_relock_8", 32'(locked), 32'd1);

      send(1'b0, 1'b0, '0);
      send(1'b0, 1'b0, '0);
      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
